// File: rtl/systolic_ctrl.sv
// Sequencer for a 2x2 output-stationary systolic matmul array: latches A/B, clears the
// array, feeds the skewed wavefront, waits DRAIN_CYCLES and captures the accumulators.
module systolic_ctrl #(
  parameter int DATA_W       = 8,
  parameter int ACC_W        = 18,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] a00,
  input  logic signed [DATA_W-1:0] a01,
  input  logic signed [DATA_W-1:0] a10,
  input  logic signed [DATA_W-1:0] a11,
  input  logic signed [DATA_W-1:0] b00,
  input  logic signed [DATA_W-1:0] b01,
  input  logic signed [DATA_W-1:0] b10,
  input  logic signed [DATA_W-1:0] b11,
  output logic                     busy,
  output logic                     done,
  output logic signed [ACC_W-1:0]  c00,
  output logic signed [ACC_W-1:0]  c01,
  output logic signed [ACC_W-1:0]  c10,
  output logic signed [ACC_W-1:0]  c11_o,
  output logic                     arr_rst,
  output logic signed [DATA_W-1:0] arr_a1,
  output logic signed [DATA_W-1:0] arr_a2,
  output logic signed [DATA_W-1:0] arr_b1,
  output logic signed [DATA_W-1:0] arr_b2,
  input  logic signed [ACC_W-1:0]  arr_c11,
  input  logic signed [ACC_W-1:0]  arr_c12,
  input  logic signed [ACC_W-1:0]  arr_c21,
  input  logic signed [ACC_W-1:0]  arr_c22
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_FEED0 = 3'd2,
    S_FEED1 = 3'd3,
    S_FEED2 = 3'd4,
    S_DRAIN = 3'd5
  } state_t;

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

  state_t                    r_state;
  logic [3:0]                r_cnt;
  logic signed [DATA_W-1:0]  r_a00, r_a01, r_a10, r_a11;
  logic signed [DATA_W-1:0]  r_b00, r_b01, r_b10, r_b11;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a00   <= '0;
      r_a01   <= '0;
      r_a10   <= '0;
      r_a11   <= '0;
      r_b00   <= '0;
      r_b01   <= '0;
      r_b10   <= '0;
      r_b11   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      c00     <= '0;
      c01     <= '0;
      c10     <= '0;
      c11_o   <= '0;
      arr_rst <= 1'b1;
      arr_a1  <= '0;
      arr_a2  <= '0;
      arr_b1  <= '0;
      arr_b2  <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // The done cycle is an IDLE cycle, so a held start re-triggers with no gap.
          busy    <= start;
          arr_rst <= start;
          arr_a1  <= '0;
          arr_a2  <= '0;
          arr_b1  <= '0;
          arr_b2  <= '0;
          if (start) begin
            r_a00   <= a00;
            r_a01   <= a01;
            r_a10   <= a10;
            r_a11   <= a11;
            r_b00   <= b00;
            r_b01   <= b01;
            r_b10   <= b10;
            r_b11   <= b11;
            r_state <= S_CLR;
          end
        end
        S_CLR: begin
          arr_rst <= 1'b0;
          arr_a1  <= r_a00;
          arr_b1  <= r_b00;
          arr_a2  <= '0;
          arr_b2  <= '0;
          r_state <= S_FEED0;
        end
        S_FEED0: begin
          arr_a1  <= r_a01;
          arr_b1  <= r_b10;
          arr_a2  <= r_a10;
          arr_b2  <= r_b01;
          r_state <= S_FEED1;
        end
        S_FEED1: begin
          arr_a1  <= '0;
          arr_b1  <= '0;
          arr_a2  <= r_a11;
          arr_b2  <= r_b11;
          r_state <= S_FEED2;
        end
        S_FEED2: begin
          arr_a1  <= '0;
          arr_b1  <= '0;
          arr_a2  <= '0;
          arr_b2  <= '0;
          r_cnt   <= DRAIN_INIT;
          r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          // Outputs change only at this capture edge; results then hold until the next job.
          if (r_cnt == 4'd1) begin
            c00     <= arr_c11;
            c01     <= arr_c12;
            c10     <= arr_c21;
            c11_o   <= arr_c22;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          busy    <= 1'b0;
          arr_rst <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
